// File: rtl/lsu_dccm_pkg.sv
// Shared types for the LSU DCCM arbiter: read-owner states and the one-hot grant.
// Pure declarations, no logic.
package lsu_dccm_pkg;

    localparam int DMA_WAIT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD   = 2'd1,
        DMA  = 2'd2
    } rd_owner_e;

    typedef struct packed {
        logic ld;
        logic sb;
        logic dma;
    } dccm_gnt_t;

endpackage

// File: rtl/lsu_dccm_prio_sel.sv
// Fixed-priority one-hot select: forced DMA, urgent store, load, store, DMA.
// Purely combinational; a request is refused only by a higher-priority one.
module lsu_dccm_prio_sel
    import lsu_dccm_pkg::*;
(
    input  logic      force_dma,
    input  logic      sb_urgent,
    input  dccm_gnt_t req,
    output dccm_gnt_t gnt
);

    always_comb begin
        gnt = '0;
        if (force_dma && req.dma) begin
            gnt.dma = 1'b1;
        end else if (sb_urgent && req.sb) begin
            gnt.sb = 1'b1;
        end else if (req.ld) begin
            gnt.ld = 1'b1;
        end else if (req.sb) begin
            gnt.sb = 1'b1;
        end else if (req.dma) begin
            gnt.dma = 1'b1;
        end
    end

endmodule

// File: rtl/lsu_dccm_arb.sv
// DCCM single-port arbiter: grants and DCCM controls are combinational, read data returns one cycle later.
// Refused requesters simply hold their request; DMA starvation is bounded by a saturating wait counter.
module lsu_dccm_arb
    import lsu_dccm_pkg::*;
#(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_FDATA_WIDTH = 39,
    parameter int DMA_MAX_WAIT     = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_valid,
    input  logic [DCCM_BITS-1:0]        ld_addr_lo,
    input  logic [DCCM_BITS-1:0]        ld_addr_hi,
    output logic                        ld_ready,
    output logic                        ld_rd_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] ld_rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] ld_rd_data_hi,
    input  logic                        sb_valid,
    input  logic                        sb_full,
    input  logic [DCCM_BITS-1:0]        sb_addr_lo,
    input  logic [DCCM_BITS-1:0]        sb_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] sb_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] sb_data_hi,
    output logic                        sb_ready,
    input  logic                        dma_valid,
    input  logic                        dma_write,
    input  logic [DCCM_BITS-1:0]        dma_addr,
    input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
    output logic                        dma_ready,
    output logic                        dma_rd_valid,
    output logic [DCCM_FDATA_WIDTH-1:0] dma_rd_data,
    output logic                        dccm_wren,
    output logic                        dccm_rden,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi
);

    localparam logic [DMA_WAIT_W-1:0] MAX_WAIT = DMA_WAIT_W'(DMA_MAX_WAIT);

    logic [DMA_WAIT_W-1:0] dma_wait_q;
    rd_owner_e             rd_owner_q;
    dccm_gnt_t             req;
    dccm_gnt_t             gnt;
    logic                  dma_wr_gnt;
    logic                  dma_rd_gnt;

    // Masking requests in reset keeps every grant and DCCM control low.
    assign req.ld  = ld_valid  & ~rst;
    assign req.sb  = sb_valid  & ~rst;
    assign req.dma = dma_valid & ~rst;

    lsu_dccm_prio_sel u_prio_sel (
        .force_dma (dma_wait_q == MAX_WAIT),
        .sb_urgent (sb_full),
        .req       (req),
        .gnt       (gnt)
    );

    assign ld_ready   = gnt.ld;
    assign sb_ready   = gnt.sb;
    assign dma_ready  = gnt.dma;
    assign dma_wr_gnt = gnt.dma &  dma_write;
    assign dma_rd_gnt = gnt.dma & ~dma_write;

    always_comb begin
        dccm_wren       = gnt.sb | dma_wr_gnt;
        dccm_rden       = gnt.ld | dma_rd_gnt;
        dccm_wr_addr_lo = '0;
        dccm_wr_addr_hi = '0;
        dccm_wr_data_lo = '0;
        dccm_wr_data_hi = '0;
        dccm_rd_addr_lo = '0;
        dccm_rd_addr_hi = '0;
        if (gnt.sb) begin
            dccm_wr_addr_lo = sb_addr_lo;
            dccm_wr_addr_hi = sb_addr_hi;
            dccm_wr_data_lo = sb_data_lo;
            dccm_wr_data_hi = sb_data_hi;
        end else if (dma_wr_gnt) begin
            dccm_wr_addr_lo = dma_addr;
            dccm_wr_addr_hi = dma_addr;
            dccm_wr_data_lo = dma_wdata;
            dccm_wr_data_hi = dma_wdata;
        end
        if (gnt.ld) begin
            dccm_rd_addr_lo = ld_addr_lo;
            dccm_rd_addr_hi = ld_addr_hi;
        end else if (dma_rd_gnt) begin
            dccm_rd_addr_lo = dma_addr;
            dccm_rd_addr_hi = dma_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dma_wait_q <= '0;
        end else if (!dma_valid || gnt.dma) begin
            dma_wait_q <= '0;
        end else if (dma_wait_q != MAX_WAIT) begin
            dma_wait_q <= dma_wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner_q <= IDLE;
        end else if (gnt.ld) begin
            rd_owner_q <= LD;
        end else if (dma_rd_gnt) begin
            rd_owner_q <= DMA;
        end else begin
            rd_owner_q <= IDLE;
        end
    end

    // A read in flight when reset hits is dropped, not returned.
    always_comb begin
        ld_rd_valid   = ~rst && (rd_owner_q == LD);
        dma_rd_valid  = ~rst && (rd_owner_q == DMA);
        ld_rd_data_lo = ld_rd_valid  ? dccm_rd_data_lo : '0;
        ld_rd_data_hi = ld_rd_valid  ? dccm_rd_data_hi : '0;
        dma_rd_data   = dma_rd_valid ? dccm_rd_data_lo : '0;
    end

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed, table-driven bench for lsu_dccm_arb with DMA_MAX_WAIT=3.
module tb_lsu_dccm_arb;

    localparam int AW = 16;
    localparam int DW = 39;

    localparam logic [AW-1:0] LD_LO   = 16'h0040;
    localparam logic [AW-1:0] LD_HI   = 16'h0044;
    localparam logic [AW-1:0] SB_LO   = 16'h0080;
    localparam logic [AW-1:0] SB_HI   = 16'h0084;
    localparam logic [DW-1:0] SB_DLO  = 39'h11;
    localparam logic [DW-1:0] SB_DHI  = 39'h22;
    localparam logic [AW-1:0] DMA_A   = 16'h0100;
    localparam logic [DW-1:0] DMA_D   = 39'h3C;

    logic clk = 1'b0;
    logic rst;
    logic ld_valid, ld_ready, ld_rd_valid;
    logic [AW-1:0] ld_addr_lo, ld_addr_hi;
    logic [DW-1:0] ld_rd_data_lo, ld_rd_data_hi;
    logic sb_valid, sb_full, sb_ready;
    logic [AW-1:0] sb_addr_lo, sb_addr_hi;
    logic [DW-1:0] sb_data_lo, sb_data_hi;
    logic dma_valid, dma_write, dma_ready, dma_rd_valid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rd_data;
    logic dccm_wren, dccm_rden;
    logic [AW-1:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
    logic [DW-1:0] dccm_wr_data_lo, dccm_wr_data_hi, dccm_rd_data_lo, dccm_rd_data_hi;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_dccm_arb #(
        .DCCM_BITS        (AW),
        .DCCM_FDATA_WIDTH (DW),
        .DMA_MAX_WAIT     (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_valid        (ld_valid),
        .ld_addr_lo      (ld_addr_lo),
        .ld_addr_hi      (ld_addr_hi),
        .ld_ready        (ld_ready),
        .ld_rd_valid     (ld_rd_valid),
        .ld_rd_data_lo   (ld_rd_data_lo),
        .ld_rd_data_hi   (ld_rd_data_hi),
        .sb_valid        (sb_valid),
        .sb_full         (sb_full),
        .sb_addr_lo      (sb_addr_lo),
        .sb_addr_hi      (sb_addr_hi),
        .sb_data_lo      (sb_data_lo),
        .sb_data_hi      (sb_data_hi),
        .sb_ready        (sb_ready),
        .dma_valid       (dma_valid),
        .dma_write       (dma_write),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_ready       (dma_ready),
        .dma_rd_valid    (dma_rd_valid),
        .dma_rd_data     (dma_rd_data),
        .dccm_wren       (dccm_wren),
        .dccm_rden       (dccm_rden),
        .dccm_wr_addr_lo (dccm_wr_addr_lo),
        .dccm_wr_addr_hi (dccm_wr_addr_hi),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_rd_addr_hi (dccm_rd_addr_hi),
        .dccm_wr_data_lo (dccm_wr_data_lo),
        .dccm_wr_data_hi (dccm_wr_data_hi),
        .dccm_rd_data_lo (dccm_rd_data_lo),
        .dccm_rd_data_hi (dccm_rd_data_hi)
    );

    logic any_out;
    assign any_out = |{ld_ready, sb_ready, dma_ready, ld_rd_valid, dma_rd_valid,
                       dccm_wren, dccm_rden, dccm_wr_addr_lo, dccm_wr_addr_hi,
                       dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
                       ld_rd_data_lo, ld_rd_data_hi, dma_rd_data};

    // g: expected grant 0=none 1=load 2=store 3=dma
    typedef struct {
        logic ld;
        logic sb;
        logic full;
        logic dma;
        logic dwr;
        int   g;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic clear_req();
        ld_valid  = 1'b0;
        sb_valid  = 1'b0;
        sb_full   = 1'b0;
        dma_valid = 1'b0;
        dma_write = 1'b0;
        ld_addr_lo = LD_LO;  ld_addr_hi = LD_HI;
        sb_addr_lo = SB_LO;  sb_addr_hi = SB_HI;
        sb_data_lo = SB_DLO; sb_data_hi = SB_DHI;
        dma_addr = DMA_A;    dma_wdata = DMA_D;
    endtask

    initial begin
        int   prev_g;
        logic prev_w;
        logic [DW-1:0] rlo, rhi;

        //          ld   sb   full dma  dwr  g
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,3};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,3};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,2};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,2};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,2};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1};
        tbl[13] = '{1'b1,1'b1,1'b1,1'b1,1'b0,3};
        tbl[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,2};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,0};
        tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b0,3};
        tbl[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1};
        tbl[20] = '{1'b0,1'b0,1'b0,1'b1,1'b0,3};
        tbl[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,0};

        // Reset with every requester active: all outputs must stay low.
        clear_req();
        rst = 1'b1;
        ld_valid = 1'b1; sb_valid = 1'b1; dma_valid = 1'b1;
        dccm_rd_data_lo = '1; dccm_rd_data_hi = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs_zero", 0, 64'(any_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_req();
        @(negedge clk);
        chk("post_rst_idle", 0, 64'(any_out), 64'd0);

        prev_g = 0;
        prev_w = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            clear_req();
            ld_valid  = tbl[i].ld;
            sb_valid  = tbl[i].sb;
            sb_full   = tbl[i].full;
            dma_valid = tbl[i].dma;
            dma_write = tbl[i].dwr;
            rlo = DW'(i) + 39'h100;
            rhi = DW'(i) + 39'h200;
            dccm_rd_data_lo = rlo;
            dccm_rd_data_hi = rhi;
            @(negedge clk);
            chk("ld_ready",  i, 64'(ld_ready),  64'(tbl[i].g == 1));
            chk("sb_ready",  i, 64'(sb_ready),  64'(tbl[i].g == 2));
            chk("dma_ready", i, 64'(dma_ready), 64'(tbl[i].g == 3));
            chk("wren", i, 64'(dccm_wren), 64'(tbl[i].g == 2 || (tbl[i].g == 3 && tbl[i].dwr)));
            chk("rden", i, 64'(dccm_rden), 64'(tbl[i].g == 1 || (tbl[i].g == 3 && !tbl[i].dwr)));
            chk("wr_addr_lo", i, 64'(dccm_wr_addr_lo),
                tbl[i].g == 2 ? 64'(SB_LO) : (tbl[i].g == 3 && tbl[i].dwr) ? 64'(DMA_A) : 64'd0);
            chk("wr_addr_hi", i, 64'(dccm_wr_addr_hi),
                tbl[i].g == 2 ? 64'(SB_HI) : (tbl[i].g == 3 && tbl[i].dwr) ? 64'(DMA_A) : 64'd0);
            chk("wr_data_hi", i, 64'(dccm_wr_data_hi),
                tbl[i].g == 2 ? 64'(SB_DHI) : (tbl[i].g == 3 && tbl[i].dwr) ? 64'(DMA_D) : 64'd0);
            chk("rd_addr_lo", i, 64'(dccm_rd_addr_lo),
                tbl[i].g == 1 ? 64'(LD_LO) : (tbl[i].g == 3 && !tbl[i].dwr) ? 64'(DMA_A) : 64'd0);
            chk("rd_addr_hi", i, 64'(dccm_rd_addr_hi),
                tbl[i].g == 1 ? 64'(LD_HI) : (tbl[i].g == 3 && !tbl[i].dwr) ? 64'(DMA_A) : 64'd0);
            chk("ld_rd_valid",  i, 64'(ld_rd_valid),  64'(prev_g == 1));
            chk("dma_rd_valid", i, 64'(dma_rd_valid), 64'(prev_g == 3 && !prev_w));
            chk("ld_rd_data_lo", i, 64'(ld_rd_data_lo), prev_g == 1 ? 64'(rlo) : 64'd0);
            chk("ld_rd_data_hi", i, 64'(ld_rd_data_hi), prev_g == 1 ? 64'(rhi) : 64'd0);
            chk("dma_rd_data",   i, 64'(dma_rd_data), (prev_g == 3 && !prev_w) ? 64'(rlo) : 64'd0);
            prev_g = tbl[i].g;
            prev_w = tbl[i].dwr;
        end

        // Load with DCCM returning 0x12/0x34 one cycle later.
        @(posedge clk); #1;
        clear_req();
        ld_valid = 1'b1;
        @(negedge clk);
        chk("seq_ld_ready", 0, 64'(ld_ready), 64'd1);
        chk("seq_ld_rden",  0, 64'(dccm_rden), 64'd1);
        chk("seq_ld_addr",  0, {32'd0, dccm_rd_addr_hi, dccm_rd_addr_lo}, 64'h0044_0040);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        dccm_rd_data_lo = 39'h12;
        dccm_rd_data_hi = 39'h34;
        @(negedge clk);
        chk("seq_ld_rd_valid", 0, 64'(ld_rd_valid), 64'd1);
        chk("seq_ld_rd_lo", 0, 64'(ld_rd_data_lo), 64'h12);
        chk("seq_ld_rd_hi", 0, 64'(ld_rd_data_hi), 64'h34);
        chk("seq_ld_ready_off", 0, 64'(ld_ready), 64'd0);

        // DMA write to 0x0200 with 0x5A on both lanes.
        @(posedge clk); #1;
        dma_valid = 1'b1;
        dma_write = 1'b1;
        dma_addr  = 16'h0200;
        dma_wdata = 39'h5A;
        @(negedge clk);
        chk("seq_dw_ready", 0, 64'(dma_ready), 64'd1);
        chk("seq_dw_en", 0, {62'd0, dccm_wren, dccm_rden}, 64'b10);
        chk("seq_dw_addr", 0, {32'd0, dccm_wr_addr_hi, dccm_wr_addr_lo}, 64'h0200_0200);
        chk("seq_dw_data_lo", 0, 64'(dccm_wr_data_lo), 64'h5A);
        chk("seq_dw_data_hi", 0, 64'(dccm_wr_data_hi), 64'h5A);
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        chk("seq_dw_no_rd_valid", 0, 64'(dma_rd_valid), 64'd0);

        // Reset the cycle after a load grant drops the pending read data.
        @(posedge clk); #1;
        ld_valid = 1'b1;
        @(negedge clk);
        chk("seq_rst_ld_ready", 0, 64'(ld_ready), 64'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        rst = 1'b1;
        dccm_rd_data_lo = 39'h77;
        dccm_rd_data_hi = 39'h77;
        @(negedge clk);
        chk("seq_rst_rd_valid", 0, 64'(ld_rd_valid), 64'd0);
        chk("seq_rst_rd_data", 0, 64'(ld_rd_data_lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("seq_rst_release_idle", k, 64'(any_out), 64'd0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
